// File: rtl/mem_bus_ctrl_if.sv
// Core-side and bus-side signals of the memory bus controller.
// The master modport is the controller's view; slave is the core/device environment.
interface mem_bus_ctrl_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_dout;
  logic        mem_read_en;
  logic        mem_write_en;
  logic [1:0]  mem_width;
  logic [31:0] mem_din;
  logic        mem_ready;
  logic        mem_fault;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_req;
  logic        bus_we;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    input  mem_addr, mem_dout, mem_read_en, mem_write_en, mem_width,
    input  bus_ack, bus_rdata,
    output mem_din, mem_ready, mem_fault,
    output bus_addr, bus_wdata, bus_be, bus_req, bus_we
  );

  modport slave (
    output mem_addr, mem_dout, mem_read_en, mem_write_en, mem_width,
    output bus_ack, bus_rdata,
    input  mem_din, mem_ready, mem_fault,
    input  bus_addr, bus_wdata, bus_be, bus_req, bus_we
  );
endinterface

// File: rtl/mem_bus_ctrl.sv
// Bridges core byte/half/word loads and stores onto a word-wide req/ack bus.
// Define MEM_BUS_TIMEOUT_EN to fault a WAIT that sees no ack within TIMEOUT_CYCLES.
module mem_bus_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic            clk,
  input logic            reset,
  mem_bus_ctrl_if.master bif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DONE  = 2'd2,
    FAULT = 2'd3
  } state_t;

  state_t     state;
  logic [1:0] width_q;
  logic [1:0] addr_lo_q;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_timeout_range
    $error("mem_bus_ctrl: TIMEOUT_CYCLES must be within 1..65535");
  end

`ifdef MEM_BUS_TIMEOUT_EN
  localparam logic [16:0] TIMEOUT_LIMIT = 17'(TIMEOUT_CYCLES);
  logic [15:0] wait_cnt;
  logic [16:0] wait_cnt_next;
  assign wait_cnt_next = {1'b0, wait_cnt} + 17'd1;
`endif

  function automatic logic is_illegal(input logic rd, input logic wr,
                                      input logic [1:0] width, input logic [1:0] lo);
    logic bad;
    bad = rd && wr;
    case (width)
      2'd0:    bad = bad;
      2'd1:    bad = bad || lo[0];
      2'd2:    bad = bad || (lo != 2'd0);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [3:0] lane_be(input logic [1:0] width, input logic [1:0] lo);
    case (width)
      2'd0:    return 4'b0001 << lo;
      2'd1:    return lo[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [1:0] width, input logic [31:0] d);
    case (width)
      2'd0:    return {4{d[7:0]}};
      2'd1:    return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  // Picks the addressed byte/half out of the bus word and zero-extends it
  function automatic logic [31:0] load_extract(input logic [1:0] width, input logic [1:0] lo,
                                               input logic [31:0] rdata);
    logic [7:0] b;
    case (lo)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      default: b = rdata[31:24];
    endcase
    case (width)
      2'd0:    return {24'b0, b};
      2'd1:    return {16'b0, (lo[1] ? rdata[31:16] : rdata[15:0])};
      default: return rdata;
    endcase
  endfunction

  // All outputs are registered and updated on state transitions, so the
  // output set always matches the state currently held.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      width_q       <= 2'd0;
      addr_lo_q     <= 2'd0;
      bif.mem_din   <= 32'd0;
      bif.mem_ready <= 1'b0;
      bif.mem_fault <= 1'b0;
      bif.bus_addr  <= 32'd0;
      bif.bus_wdata <= 32'd0;
      bif.bus_be    <= 4'd0;
      bif.bus_req   <= 1'b0;
      bif.bus_we    <= 1'b0;
`ifdef MEM_BUS_TIMEOUT_EN
      wait_cnt      <= 16'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          bif.mem_din   <= 32'd0;
          bif.mem_ready <= 1'b0;
          bif.mem_fault <= 1'b0;
          if (bif.mem_read_en || bif.mem_write_en) begin
            if (is_illegal(bif.mem_read_en, bif.mem_write_en, bif.mem_width, bif.mem_addr[1:0])) begin
              state         <= FAULT;
              bif.mem_ready <= 1'b1;
              bif.mem_fault <= 1'b1;
            end else begin
              state         <= WAIT;
              width_q       <= bif.mem_width;
              addr_lo_q     <= bif.mem_addr[1:0];
              bif.bus_addr  <= {bif.mem_addr[31:2], 2'b00};
              bif.bus_we    <= bif.mem_write_en;
              bif.bus_be    <= bif.mem_write_en ? lane_be(bif.mem_width, bif.mem_addr[1:0]) : 4'd0;
              bif.bus_wdata <= bif.mem_write_en ? lane_wdata(bif.mem_width, bif.mem_dout) : 32'd0;
              bif.bus_req   <= 1'b1;
`ifdef MEM_BUS_TIMEOUT_EN
              wait_cnt      <= 16'd0;
`endif
            end
          end
        end
        WAIT: begin
          if (bif.bus_ack) begin
            state         <= DONE;
            bif.mem_ready <= 1'b1;
            bif.mem_din   <= bif.bus_we ? 32'd0 : load_extract(width_q, addr_lo_q, bif.bus_rdata);
            bif.bus_req   <= 1'b0;
            bif.bus_we    <= 1'b0;
            bif.bus_be    <= 4'd0;
            bif.bus_addr  <= 32'd0;
            bif.bus_wdata <= 32'd0;
          end
`ifdef MEM_BUS_TIMEOUT_EN
          // An ack arriving on the expiry cycle is taken by the branch above
          else if (wait_cnt_next == TIMEOUT_LIMIT) begin
            state         <= FAULT;
            bif.mem_ready <= 1'b1;
            bif.mem_fault <= 1'b1;
            bif.mem_din   <= 32'd0;
            bif.bus_req   <= 1'b0;
            bif.bus_we    <= 1'b0;
            bif.bus_be    <= 4'd0;
            bif.bus_addr  <= 32'd0;
            bif.bus_wdata <= 32'd0;
          end else begin
            wait_cnt <= wait_cnt_next[15:0];
          end
`endif
        end
        DONE, FAULT: begin
          state         <= IDLE;
          bif.mem_ready <= 1'b0;
          bif.mem_fault <= 1'b0;
          bif.mem_din   <= 32'd0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed self-checking bench for mem_bus_ctrl; expected values are hand-computed.
// Timeout expectations follow whether MEM_BUS_TIMEOUT_EN is defined.
module tb_mem_bus_ctrl;
  localparam int TO = 4;
`ifdef MEM_BUS_TIMEOUT_EN
  localparam int ACK_DELAY = TO - 1;
`else
  localparam int ACK_DELAY = 10;
`endif

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  mem_bus_ctrl_if bif();

  mem_bus_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bif   (bif)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rd, input logic wr, input logic [1:0] width,
                               input logic [31:0] addr, input logic [31:0] dout);
    bif.mem_read_en  = rd;
    bif.mem_write_en = wr;
    bif.mem_width    = width;
    bif.mem_addr     = addr;
    bif.mem_dout     = dout;
  endtask

  task automatic setAck(input logic ack, input logic [31:0] rdata);
    bif.bus_ack   = ack;
    bif.bus_rdata = rdata;
  endtask

  // Issues an illegal request and expects a fault pulse with no bus activity
  task automatic expectFault(input string tag, input logic rd, input logic wr,
                             input logic [1:0] width, input logic [31:0] addr);
    applyStimulus(rd, wr, width, addr, 32'h0);
    tick();
    checkOutput({tag, "_req"},   32'(bif.bus_req),   32'd0);
    checkOutput({tag, "_ready"}, 32'(bif.mem_ready), 32'd1);
    checkOutput({tag, "_fault"}, 32'(bif.mem_fault), 32'd1);
    checkOutput({tag, "_din"},   bif.mem_din,        32'd0);
    applyStimulus(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    tick();
    checkOutput({tag, "_ready_clr"}, 32'(bif.mem_ready), 32'd0);
    checkOutput({tag, "_fault_clr"}, 32'(bif.mem_fault), 32'd0);
  endtask

  initial begin
    int bad_req;
    int bad_ready;
    int cycles;

    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    setAck(1'b0, 32'h0);
    tick();
    tick();
    checkOutput("rst_ready", 32'(bif.mem_ready), 32'd0);
    checkOutput("rst_fault", 32'(bif.mem_fault), 32'd0);
    checkOutput("rst_din",   bif.mem_din,        32'd0);
    checkOutput("rst_req",   32'(bif.bus_req),   32'd0);
    checkOutput("rst_we",    32'(bif.bus_we),    32'd0);
    checkOutput("rst_be",    32'(bif.bus_be),    32'd0);
    checkOutput("rst_addr",  bif.bus_addr,       32'd0);
    checkOutput("rst_wdata", bif.bus_wdata,      32'd0);
    reset = 1'b0;
    tick();

    // LB 0x103: top byte of the bus word
    applyStimulus(1'b1, 1'b0, 2'd0, 32'h103, 32'h0);
    tick();
    checkOutput("lb_req",  32'(bif.bus_req), 32'd1);
    checkOutput("lb_addr", bif.bus_addr,     32'h100);
    checkOutput("lb_be",   32'(bif.bus_be),  32'd0);
    checkOutput("lb_we",   32'(bif.bus_we),  32'd0);
    checkOutput("lb_early_ready", 32'(bif.mem_ready), 32'd0);
    setAck(1'b1, 32'hAABBCCDD);
    tick();
    checkOutput("lb_ready", 32'(bif.mem_ready), 32'd1);
    checkOutput("lb_fault", 32'(bif.mem_fault), 32'd0);
    checkOutput("lb_din",   bif.mem_din,        32'h000000AA);
    checkOutput("lb_req_drop", 32'(bif.bus_req), 32'd0);
    applyStimulus(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    setAck(1'b0, 32'h0);
    tick();
    checkOutput("lb_ready_clr", 32'(bif.mem_ready), 32'd0);
    checkOutput("lb_din_clr",   bif.mem_din,        32'd0);

    // SH 0x202: upper half lanes, replicated data
    applyStimulus(1'b0, 1'b1, 2'd1, 32'h202, 32'h1234ABCD);
    tick();
    checkOutput("sh_req",   32'(bif.bus_req), 32'd1);
    checkOutput("sh_addr",  bif.bus_addr,     32'h200);
    checkOutput("sh_be",    32'(bif.bus_be),  32'hC);
    checkOutput("sh_wdata", bif.bus_wdata,    32'hABCDABCD);
    checkOutput("sh_we",    32'(bif.bus_we),  32'd1);
    setAck(1'b1, 32'hFFFFFFFF);
    tick();
    checkOutput("sh_ready", 32'(bif.mem_ready), 32'd1);
    checkOutput("sh_din",   bif.mem_din,        32'd0);
    applyStimulus(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    setAck(1'b0, 32'h0);
    tick();

    // SB 0x001: lane 1 enable, byte replicated
    applyStimulus(1'b0, 1'b1, 2'd0, 32'h001, 32'h0000005A);
    tick();
    checkOutput("sb_be",    32'(bif.bus_be), 32'h2);
    checkOutput("sb_wdata", bif.bus_wdata,   32'h5A5A5A5A);
    setAck(1'b1, 32'h0);
    tick();
    checkOutput("sb_ready", 32'(bif.mem_ready), 32'd1);
    applyStimulus(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    setAck(1'b0, 32'h0);
    tick();

    // LH 0x012: upper half zero-extended
    applyStimulus(1'b1, 1'b0, 2'd1, 32'h012, 32'h0);
    tick();
    checkOutput("lh_addr", bif.bus_addr, 32'h10);
    setAck(1'b1, 32'h11223344);
    tick();
    checkOutput("lh_din", bif.mem_din, 32'h00001122);
    applyStimulus(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    setAck(1'b0, 32'h0);
    tick();

    expectFault("lw_misalign", 1'b1, 1'b0, 2'd2, 32'h106);
    expectFault("rd_and_wr",   1'b1, 1'b1, 2'd2, 32'h100);
    expectFault("width3",      1'b1, 1'b0, 2'd3, 32'h100);
    expectFault("lh_odd",      1'b0, 1'b1, 2'd1, 32'h101);

    // LW 0x40 with a long ack delay; outputs must hold steady throughout
    applyStimulus(1'b1, 1'b0, 2'd2, 32'h40, 32'h0);
    tick();
    bad_req = 0;
    for (int i = 0; i < ACK_DELAY; i++) begin
      if (bif.bus_req !== 1'b1 || bif.bus_addr !== 32'h40 || bif.mem_ready !== 1'b0) bad_req++;
      tick();
    end
    checkOutput("lw_hold_bad_cycles", 32'(bad_req), 32'd0);
    checkOutput("lw_hold_req_last", 32'(bif.bus_req), 32'd1);
    setAck(1'b1, 32'h89ABCDEF);
    tick();
    checkOutput("lw_ready", 32'(bif.mem_ready), 32'd1);
    checkOutput("lw_fault", 32'(bif.mem_fault), 32'd0);
    checkOutput("lw_din",   bif.mem_din,        32'h89ABCDEF);
    applyStimulus(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    setAck(1'b0, 32'h0);
    tick();

    // Reset mid-WAIT, then a stray ack
    applyStimulus(1'b1, 1'b0, 2'd2, 32'h80, 32'h0);
    tick();
    checkOutput("rw_req_before", 32'(bif.bus_req), 32'd1);
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    tick();
    reset = 1'b0;
    checkOutput("rw_req_after",   32'(bif.bus_req),   32'd0);
    checkOutput("rw_ready_after", 32'(bif.mem_ready), 32'd0);
    setAck(1'b1, 32'h12345678);
    tick();
    checkOutput("rw_late_ack_ready", 32'(bif.mem_ready), 32'd0);
    checkOutput("rw_late_ack_req",   32'(bif.bus_req),   32'd0);
    setAck(1'b0, 32'h0);
    tick();
    applyStimulus(1'b1, 1'b0, 2'd0, 32'h81, 32'h0);
    tick();
    checkOutput("rw_next_req", 32'(bif.bus_req), 32'd1);
    setAck(1'b1, 32'h11223344);
    tick();
    checkOutput("rw_next_ready", 32'(bif.mem_ready), 32'd1);
    checkOutput("rw_next_din",   bif.mem_din,        32'h00000033);
    applyStimulus(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    setAck(1'b0, 32'h0);
    tick();

    // No ack at all
    applyStimulus(1'b1, 1'b0, 2'd2, 32'h44, 32'h0);
    tick();
`ifdef MEM_BUS_TIMEOUT_EN
    cycles = 0;
    while (bif.mem_ready !== 1'b1 && cycles < 20) begin
      tick();
      cycles++;
    end
    checkOutput("to_wait_cycles", 32'(cycles), 32'(TO));
    checkOutput("to_fault", 32'(bif.mem_fault), 32'd1);
    checkOutput("to_req",   32'(bif.bus_req),   32'd0);
    applyStimulus(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    tick();
    checkOutput("to_req_after",   32'(bif.bus_req),   32'd0);
    checkOutput("to_ready_after", 32'(bif.mem_ready), 32'd0);
`else
    bad_req = 0;
    bad_ready = 0;
    cycles = 0;
    for (int i = 0; i < 100; i++) begin
      if (bif.bus_req !== 1'b1) bad_req++;
      if (bif.mem_ready !== 1'b0 || bif.mem_fault !== 1'b0) bad_ready++;
      tick();
      cycles++;
    end
    checkOutput("noto_req_dropped", 32'(bad_req),   32'd0);
    checkOutput("noto_pulse_seen",  32'(bad_ready), 32'd0);
    checkOutput("noto_cycles",      32'(cycles),    32'd100);
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    tick();
    reset = 1'b0;
    checkOutput("noto_req_after_reset", 32'(bif.bus_req), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_bus_ctrl.md
MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, 255, ack wait limit in cycles (range 1-65535); used only when MEM_BUS_TIMEOUT_EN is defined.
REQ-002 Port: clk  input  1  single clock; all logic on rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: mem_addr  input  32  core byte address.
REQ-005 Port: mem_dout  input  32  core store data, right-aligned.
REQ-006 Port: mem_read_en  input  1  core load request.
REQ-007 Port: mem_write_en  input  1  core store request.
REQ-008 Port: mem_width  input  2  access size: 0 byte, 1 half, 2 word, 3 illegal.
REQ-009 Port: mem_din  output  32  load data to core, right-aligned, zero-extended (core performs sign extension).
REQ-010 Port: mem_ready  output  1  one-cycle completion pulse.
REQ-011 Port: mem_fault  output  1  one-cycle error pulse, coincident with mem_ready.
REQ-012 Port: bus_addr  output  32  word-aligned device address, bits [1:0] always 0.
REQ-013 Port: bus_wdata  output  32  lane-replicated store data.
REQ-014 Port: bus_be  output  4  byte enables.
REQ-015 Port: bus_req  output  1  device request, held until ack.
REQ-016 Port: bus_we  output  1  1 write, 0 read.
REQ-017 Port: bus_ack  input  1  device completion; sampled only while bus_req=1.
REQ-018 Port: bus_rdata  input  32  device read data, valid with bus_ack.

Function
REQ-019 FSM states: IDLE, WAIT, DONE, FAULT.
REQ-020 IDLE: request = mem_read_en|mem_write_en; legal request -> WAIT, latching addr/width/data/direction; illegal -> FAULT; none -> stay.
REQ-021 Illegal: mem_width=3; half with addr[0]=1; word with addr[1:0]!=0; read_en and write_en both 1.
REQ-022 WAIT: bus_req=1 with bus_addr/bus_wdata/bus_be/bus_we stable from latch; bus_ack=1 -> DONE, capturing bus_rdata; else stay.
REQ-023 Latency: request seen in IDLE at cycle N, bus_req high N+1, ack at cycle M>=N+1, mem_ready high M+1; minimum 2 cycles.
REQ-024 DONE: mem_ready=1, mem_fault=0, mem_din = extracted load data (0 for writes), then -> IDLE.
REQ-025 FAULT: mem_ready=1, mem_fault=1, mem_din=0, no bus transaction, then -> IDLE.
REQ-026 Byte enables: byte 4'b0001<<addr[1:0]; half addr[1]?4'b1100:4'b0011; word 4'b1111; bus_be=0 for reads.
REQ-027 Store data: byte {4{d[7:0]}}; half {2{d[15:0]}}; word d.
REQ-028 Load extract: byte {24'b0, rdata[8*addr[1:0]+7 -:8]}; half {16'b0, rdata[16*addr[1]+15 -:16]}; word rdata.
REQ-029 Outside DONE/FAULT: mem_ready=0, mem_fault=0, mem_din=0.
REQ-030 Core requests are ignored in WAIT/DONE/FAULT; request still asserted in the IDLE cycle after DONE is a new transaction (core drops request on seeing mem_ready).
REQ-031 bus_ack outside WAIT is ignored.

Reset
REQ-032 reset=1 at an edge: state IDLE, latches and timeout counter cleared; next cycle all outputs 0.
REQ-033 Reset mid-WAIT drops bus_req the next cycle with no mem_ready; a late bus_ack is ignored.

Configuration
REQ-034 Macro MEM_BUS_TIMEOUT_EN defined: counter clears on WAIT entry, increments each WAIT cycle without ack; on reaching TIMEOUT_CYCLES -> FAULT, bus_req dropped next cycle; ack in the same cycle as expiry wins (-> DONE).
REQ-035 MEM_BUS_TIMEOUT_EN undefined: no counter; WAIT persists until bus_ack or reset; TIMEOUT_CYCLES unused.

Verification
REQ-036 LB addr=0x103, width=0, rdata=0xAABBCCDD, ack one cycle after req -> bus_addr=0x100, bus_be=0, mem_din=0x000000AA, mem_ready 2 cycles after request.
REQ-037 SH addr=0x202, width=1, dout=0x1234ABCD -> bus_be=4'b1100, bus_wdata=0xABCDABCD, bus_we=1, mem_ready one cycle after ack, mem_din=0.
REQ-038 LW addr=0x106 -> no bus_req, mem_ready=mem_fault=1 next cycle; read_en=write_en=1 -> same fault.
REQ-039 LW addr=0x40, ack delayed 10 cycles -> bus_req and bus_addr=0x40 stable for all 10 cycles, mem_din=rdata one cycle after ack.
REQ-040 Reset pulsed during WAIT, then ack asserted -> bus_req low after reset, no mem_ready, next request serviced normally.
REQ-041 MEM_BUS_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> mem_fault pulse after 4 WAIT cycles, bus_req low afterwards; undefined -> bus_req held for 100 cycles, no pulse.
